// File: rtl/cfeb_sched_pkg.sv
// Shared state encodings and default widths for the CFEB SCA block scheduler.
package cfeb_sched_pkg;

    localparam int NBLK_DEF   = 16;
    localparam int BLK_W_DEF  = 4;
    localparam int NSAMP_DEF  = 8;
    localparam int SAMP_W_DEF = 3;
    localparam int L1AN_W     = 6;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_CAP  = 1'b1
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_BUSY = 2'd2,
        R_FREE = 2'd3
    } rstate_t;

endpackage

// File: rtl/blk_fifo.sv
// Show-ahead synchronous FIFO; a pop is judged on the occupancy before any
// same-cycle push, so an entry written this cycle is never consumed.
module blk_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != (AW+1)'(DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (pop_ok)  rd_ptr_q <= nextPtr(rd_ptr_q);
            if (push_ok) wr_ptr_q <= nextPtr(wr_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/sca_blk_sched.sv
// SCA block scheduler: allocates capture blocks on LCT, resolves them on L1A
// and hands matched blocks to the readout sequencer.
module sca_blk_sched
    import cfeb_sched_pkg::*;
#(
    parameter int TMR    = 1,
    parameter int NBLK   = NBLK_DEF,
    parameter int BLK_W  = BLK_W_DEF,
    parameter int NSAMP  = NSAMP_DEF,
    parameter int SAMP_W = SAMP_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_B,
    input  logic                    LCT,
    input  logic                    L1A_MATCH,
    input  logic                    L1A_NOMATCH,
    input  logic                    RD_ACK,
    input  logic                    RD_DONE,
    output logic                    WR_EN,
    output logic [BLK_W+SAMP_W-1:0] WADR,
    output logic                    RD_REQ,
    output logic [BLK_W-1:0]        RBLK,
    output logic [L1AN_W-1:0]       RD_L1AN,
    output logic [BLK_W:0]          FREE_CNT,
    output logic                    DATAAVAIL,
    output logic                    OVFL,
    output logic                    L1A_ERR,
    output logic [7:0]              LOST_CNT
);

    localparam int NCOPY = (TMR != 0) ? 3 : 1;
    localparam int RQ_W  = BLK_W + L1AN_W;

    logic [0:0]      wst_q  [NCOPY];
    logic [1:0]      rdst_q [NCOPY];
    logic [NBLK-1:0] mask_q [NCOPY];
    logic [0:0]      wst_v;
    logic [1:0]      rdst_v;
    logic [NBLK-1:0] mask;
    wstate_t         wst, wst_d;
    rstate_t         rdst, rdst_d;
    logic [NBLK-1:0] mask_d;

    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [SAMP_W-1:0] samp_q, samp_d;
    logic              wr_en_q, wr_en_d;
    logic              ovfl_q;
    logic [7:0]        lost_q;
    logic              err_q;
    logic [L1AN_W-1:0] l1an_q;
    logic              rd_req_q, rd_req_d;
    logic [BLK_W-1:0]  rblk_q, rblk_d;
    logic [L1AN_W-1:0] rl1an_q, rl1an_d;
    logic [BLK_W:0]    free_cnt_q, free_cnt_d;

    logic [BLK_W-1:0] low_idx;
    logic             alloc, lost, cap_done;
    logic             pq_pop, pq_empty, rq_push, rq_pop, rq_empty, nm_free;
    logic [BLK_W-1:0] pq_head;
    logic [RQ_W-1:0]  rq_head;

    // Majority vote across the three copies masks a single upset register.
    generate
        if (NCOPY == 3) begin : g_tmr
            assign wst_v  = (wst_q[0] & wst_q[1]) | (wst_q[0] & wst_q[2]) | (wst_q[1] & wst_q[2]);
            assign rdst_v = (rdst_q[0] & rdst_q[1]) | (rdst_q[0] & rdst_q[2]) | (rdst_q[1] & rdst_q[2]);
            assign mask   = (mask_q[0] & mask_q[1]) | (mask_q[0] & mask_q[2]) | (mask_q[1] & mask_q[2]);
        end else begin : g_single
            assign wst_v  = wst_q[0];
            assign rdst_v = rdst_q[0];
            assign mask   = mask_q[0];
        end
    endgenerate

    assign wst  = wstate_t'(wst_v);
    assign rdst = rstate_t'(rdst_v);

    always_comb begin
        low_idx    = '0;
        free_cnt_d = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (mask[i]) low_idx = BLK_W'(i);
        end
        for (int i = 0; i < NBLK; i++) begin
            free_cnt_d = free_cnt_d + (BLK_W+1)'(mask[i]);
        end
    end

    assign alloc    = LCT && (wst == W_IDLE) && (free_cnt_q != '0);
    assign lost     = LCT && !alloc;
    assign cap_done = (wst == W_CAP) && (samp_q == SAMP_W'(NSAMP - 1));

    // A simultaneous MATCH/NOMATCH resolves as MATCH; the error flag records it.
    assign pq_pop  = (L1A_MATCH || L1A_NOMATCH) && !pq_empty;
    assign rq_push = L1A_MATCH && !pq_empty;
    assign nm_free = L1A_NOMATCH && !L1A_MATCH && !pq_empty;

    blk_fifo #(.WIDTH(BLK_W), .DEPTH(NBLK)) u_pend (
        .clk    (CLK),
        .rst_n  (RST_B),
        .push_i (cap_done),
        .din_i  (blk_q),
        .pop_i  (pq_pop),
        .dout_o (pq_head),
        .empty_o(pq_empty)
    );

    blk_fifo #(.WIDTH(RQ_W), .DEPTH(NBLK)) u_ready (
        .clk    (CLK),
        .rst_n  (RST_B),
        .push_i (rq_push),
        .din_i  ({pq_head, l1an_q}),
        .pop_i  (rq_pop),
        .dout_o (rq_head),
        .empty_o(rq_empty)
    );

    always_comb begin
        wst_d   = wst;
        blk_d   = blk_q;
        samp_d  = samp_q;
        wr_en_d = wr_en_q;
        case (wst)
            W_IDLE: begin
                if (alloc) begin
                    blk_d   = low_idx;
                    samp_d  = '0;
                    wr_en_d = 1'b1;
                    wst_d   = W_CAP;
                end
            end
            W_CAP: begin
                if (cap_done) begin
                    samp_d  = '0;
                    wr_en_d = 1'b0;
                    wst_d   = W_IDLE;
                end else begin
                    samp_d = samp_q + SAMP_W'(1);
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        rdst_d   = rdst;
        rq_pop   = 1'b0;
        rd_req_d = rd_req_q;
        rblk_d   = rblk_q;
        rl1an_d  = rl1an_q;
        case (rdst)
            R_IDLE: begin
                if (!rq_empty) begin
                    rq_pop   = 1'b1;
                    rblk_d   = rq_head[RQ_W-1:L1AN_W];
                    rl1an_d  = rq_head[L1AN_W-1:0];
                    rd_req_d = 1'b1;
                    rdst_d   = R_REQ;
                end
            end
            R_REQ: begin
                if (RD_ACK) begin
                    rd_req_d = 1'b0;
                    rdst_d   = R_BUSY;
                end
            end
            R_BUSY: begin
                if (RD_DONE) rdst_d = R_FREE;
            end
            default: rdst_d = R_IDLE;
        endcase
    end

    // The three mask updates always target distinct blocks, so all apply.
    always_comb begin
        mask_d = mask;
        if (alloc)          mask_d[low_idx] = 1'b0;
        if (nm_free)        mask_d[pq_head] = 1'b1;
        if (rdst == R_FREE) mask_d[rblk_q]  = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int k = 0; k < NCOPY; k++) begin
                wst_q[k]  <= W_IDLE;
                rdst_q[k] <= R_IDLE;
                mask_q[k] <= '1;
            end
            blk_q      <= '0;
            samp_q     <= '0;
            wr_en_q    <= 1'b0;
            ovfl_q     <= 1'b0;
            lost_q     <= '0;
            err_q      <= 1'b0;
            l1an_q     <= '0;
            rd_req_q   <= 1'b0;
            rblk_q     <= '0;
            rl1an_q    <= '0;
            free_cnt_q <= (BLK_W+1)'(NBLK);
        end else begin
            for (int k = 0; k < NCOPY; k++) begin
                wst_q[k]  <= wst_d;
                rdst_q[k] <= rdst_d;
                mask_q[k] <= mask_d;
            end
            blk_q      <= blk_d;
            samp_q     <= samp_d;
            wr_en_q    <= wr_en_d;
            rd_req_q   <= rd_req_d;
            rblk_q     <= rblk_d;
            rl1an_q    <= rl1an_d;
            free_cnt_q <= free_cnt_d;
            if (lost) begin
                ovfl_q <= 1'b1;
                if (lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
            end
            if (((L1A_MATCH || L1A_NOMATCH) && pq_empty) || (L1A_MATCH && L1A_NOMATCH)) begin
                err_q <= 1'b1;
            end
            if (rq_push) l1an_q <= l1an_q + L1AN_W'(1);
        end
    end

    assign WR_EN     = wr_en_q;
    assign WADR      = {blk_q, samp_q};
    assign RD_REQ    = rd_req_q;
    assign RBLK      = rblk_q;
    assign RD_L1AN   = rl1an_q;
    assign FREE_CNT  = free_cnt_q;
    assign DATAAVAIL = !rq_empty || (rdst != R_IDLE);
    assign OVFL      = ovfl_q;
    assign L1A_ERR   = err_q;
    assign LOST_CNT  = lost_q;

endmodule

// File: tb/tb_sca_blk_sched.sv
// Directed bench for sca_blk_sched: capture, L1A resolution, readout, overflow and reset.
`timescale 1ns/1ps
module tb_sca_blk_sched;

    logic       CLK = 1'b0;
    logic       RST_B;
    logic       LCT, L1A_MATCH, L1A_NOMATCH, RD_ACK, RD_DONE;
    logic       WR_EN;
    logic [6:0] WADR;
    logic       RD_REQ;
    logic [3:0] RBLK;
    logic [5:0] RD_L1AN;
    logic [4:0] FREE_CNT;
    logic       DATAAVAIL, OVFL, L1A_ERR;
    logic [7:0] LOST_CNT;

    int testsRun;
    int testsFailed;

    sca_blk_sched #(.TMR(1), .NBLK(16), .BLK_W(4), .NSAMP(8), .SAMP_W(3)) dut (
        .CLK        (CLK),
        .RST_B      (RST_B),
        .LCT        (LCT),
        .L1A_MATCH  (L1A_MATCH),
        .L1A_NOMATCH(L1A_NOMATCH),
        .RD_ACK     (RD_ACK),
        .RD_DONE    (RD_DONE),
        .WR_EN      (WR_EN),
        .WADR       (WADR),
        .RD_REQ     (RD_REQ),
        .RBLK       (RBLK),
        .RD_L1AN    (RD_L1AN),
        .FREE_CNT   (FREE_CNT),
        .DATAAVAIL  (DATAAVAIL),
        .OVFL       (OVFL),
        .L1A_ERR    (L1A_ERR),
        .LOST_CNT   (LOST_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives the given pulses for exactly one sampling edge, then clears them.
    task automatic applyStimulus(input logic lct, input logic match, input logic nomatch,
                                 input logic ack, input logic done);
        LCT         = lct;
        L1A_MATCH   = match;
        L1A_NOMATCH = nomatch;
        RD_ACK      = ack;
        RD_DONE     = done;
        tick(1);
        LCT         = 1'b0;
        L1A_MATCH   = 1'b0;
        L1A_NOMATCH = 1'b0;
        RD_ACK      = 1'b0;
        RD_DONE     = 1'b0;
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_wr_en"},     32'(WR_EN),     32'd0);
        checkOutput({pfx, "_wadr"},      32'(WADR),      32'd0);
        checkOutput({pfx, "_rd_req"},    32'(RD_REQ),    32'd0);
        checkOutput({pfx, "_rblk"},      32'(RBLK),      32'd0);
        checkOutput({pfx, "_rd_l1an"},   32'(RD_L1AN),   32'd0);
        checkOutput({pfx, "_free_cnt"},  32'(FREE_CNT),  32'd16);
        checkOutput({pfx, "_dataavail"}, 32'(DATAAVAIL), 32'd0);
        checkOutput({pfx, "_ovfl"},      32'(OVFL),      32'd0);
        checkOutput({pfx, "_l1a_err"},   32'(L1A_ERR),   32'd0);
        checkOutput({pfx, "_lost_cnt"},  32'(LOST_CNT),  32'd0);
    endtask

    task automatic doReset();
        RST_B = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_B = 1'b1;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        RST_B       = 1'b1;
        LCT         = 1'b0;
        L1A_MATCH   = 1'b0;
        L1A_NOMATCH = 1'b0;
        RD_ACK      = 1'b0;
        RD_DONE     = 1'b0;

        #2 RST_B = 1'b0;
        #1;
        checkResetOutputs("rst");
        @(negedge CLK);
        RST_B = 1'b1;
        tick(1);

        // Single capture of block 0, matched and read out.
        applyStimulus(1, 0, 0, 0, 0);
        for (int s = 0; s < 8; s++) begin
            checkOutput($sformatf("t1_wr_en_%0d", s), 32'(WR_EN), 32'd1);
            checkOutput($sformatf("t1_wadr_%0d", s),  32'(WADR),  32'(s));
            tick(1);
        end
        checkOutput("t1_wr_en_off", 32'(WR_EN),    32'd0);
        checkOutput("t1_free_cnt",  32'(FREE_CNT), 32'd15);
        applyStimulus(0, 1, 0, 0, 0);
        tick(1);
        checkOutput("t1_rd_req",    32'(RD_REQ),    32'd1);
        checkOutput("t1_rblk",      32'(RBLK),      32'd0);
        checkOutput("t1_rd_l1an",   32'(RD_L1AN),   32'd0);
        checkOutput("t1_dataavail", 32'(DATAAVAIL), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t1_rd_req_ack",   32'(RD_REQ),    32'd0);
        checkOutput("t1_dataavail_bz", 32'(DATAAVAIL), 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        tick(2);
        checkOutput("t1_free_cnt_end",  32'(FREE_CNT),  32'd16);
        checkOutput("t1_dataavail_end", 32'(DATAAVAIL), 32'd0);

        // Fill all 16 blocks, then lose a 17th LCT.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("t2_wadr_%0d", i), 32'(WADR), 32'(i * 8));
            tick(9);
        end
        checkOutput("t2_free_cnt0", 32'(FREE_CNT), 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t2_wr_en",    32'(WR_EN),    32'd0);
        checkOutput("t2_ovfl",     32'(OVFL),     32'd1);
        checkOutput("t2_lost_cnt", 32'(LOST_CNT), 32'd1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0);
        tick(2);
        checkOutput("t2_free_cnt16", 32'(FREE_CNT), 32'd16);
        checkOutput("t2_l1a_err",    32'(L1A_ERR),  32'd0);

        // NOMATCH frees block 0, MATCH sends block 1 to readout.
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t3_wadr0", 32'(WADR), 32'd0);
        tick(9);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t3_wadr1", 32'(WADR), 32'd8);
        tick(9);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        tick(1);
        checkOutput("t3_rd_req",   32'(RD_REQ),   32'd1);
        checkOutput("t3_rblk",     32'(RBLK),     32'd1);
        checkOutput("t3_rd_l1an",  32'(RD_L1AN),  32'd0);
        checkOutput("t3_free_cnt", 32'(FREE_CNT), 32'd15);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        tick(2);
        checkOutput("t3_free_cnt_end", 32'(FREE_CNT), 32'd16);

        // MATCH on an empty pending queue, then 64 events to wrap the L1A number.
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t4_l1a_err", 32'(L1A_ERR), 32'd1);
        tick(2);
        checkOutput("t4_rd_req",    32'(RD_REQ),    32'd0);
        checkOutput("t4_dataavail", 32'(DATAAVAIL), 32'd0);
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1, 0, 0, 0, 0);
            tick(8);
            applyStimulus(0, 1, 0, 0, 0);
            tick(1);
            checkOutput($sformatf("t4_l1an_%0d", k), 32'(RD_L1AN), 32'((k + 1) % 64));
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 1);
            tick(2);
        end
        checkOutput("t4_free_cnt_end", 32'(FREE_CNT), 32'd16);

        // LCT during capture is lost; back-to-back LCT right after capture is taken.
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        tick(3);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t5_lost_cnt", 32'(LOST_CNT), 32'd1);
        checkOutput("t5_ovfl",     32'(OVFL),     32'd1);
        checkOutput("t5_wr_en",    32'(WR_EN),    32'd1);
        tick(4);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t5_b2b_wr_en", 32'(WR_EN), 32'd1);
        checkOutput("t5_b2b_wadr",  32'(WADR),  32'd8);
        tick(8);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("t5_l1a_err", 32'(L1A_ERR), 32'd1);
        tick(1);
        checkOutput("t5_rd_req",   32'(RD_REQ),   32'd1);
        checkOutput("t5_rblk",     32'(RBLK),     32'd0);
        checkOutput("t5_rd_l1an",  32'(RD_L1AN),  32'd0);
        checkOutput("t5_free_cnt", 32'(FREE_CNT), 32'd14);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        tick(2);
        checkOutput("t5_free_cnt_end", 32'(FREE_CNT), 32'd15);

        // Async reset while reading with three blocks out of the free pool.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_wadr0", 32'(WADR), 32'd0);
        tick(8);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_wadr2", 32'(WADR), 32'd16);
        tick(8);
        applyStimulus(0, 1, 0, 0, 0);
        tick(1);
        checkOutput("t6_rblk",    32'(RBLK),    32'd1);
        checkOutput("t6_rd_l1an", 32'(RD_L1AN), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_free_cnt",  32'(FREE_CNT),  32'd13);
        checkOutput("t6_dataavail", 32'(DATAAVAIL), 32'd1);
        #2 RST_B = 1'b0;
        #1;
        checkResetOutputs("t6_rst");
        @(negedge CLK);
        RST_B = 1'b1;
        tick(2);
        checkOutput("t6_free_cnt_rel",  32'(FREE_CNT),  32'd16);
        checkOutput("t6_rd_req_rel",    32'(RD_REQ),    32'd0);
        checkOutput("t6_dataavail_rel", 32'(DATAAVAIL), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
